mem_request_master: RTL and testbench
=====================================

Name: mem_request_master

Overview:
- Initiator side of the unified instruction/data memory port in the multicycle datapath.
- Accepts instruction-fetch and data load/store requests from the control unit and arbitrates between them.
- Checks address window and alignment, drives address/write/write_data to the memory, and holds the address for a programmable number of wait cycles.
- Captures read data and returns a one-cycle acknowledge with an error flag.

Parameters:
- WAIT_CYCLES, 0, extra cycles the address is held before read data is captured (0–15).
- CNT_W, 4, width of the wait counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- ifetch_req  in  1  instruction fetch request; level, held until ifetch_ack.
- ifetch_pc  in  32  fetch address.
- ifetch_ack  out  1  one-cycle pulse: fetch complete.
- instr  out  32  fetched word; valid while ifetch_ack is high, then held.
- data_req  in  1  data request; level, held until data_ack.
- data_we  in  1  1 = store, 0 = load.
- data_size  in  2  00 word, 01 half, 10 byte; ignored unless the feature is enabled.
- data_addr  in  32  byte address.
- data_wdata  in  32  store data; sub-word data in the low bits.
- data_ack  out  1  one-cycle pulse: data access complete.
- data_rdata  out  32  load result; valid with data_ack, then held.
- err  out  1  high with an ack when the access was rejected.
- fault_addr  out  32  address of the last rejected access.
- mem_address  out  32  to memory.
- mem_write  out  1  to memory; memory commits on the falling edge.
- mem_write_data  out  32  to memory.
- mem_read_data  in  32  from memory; combinational function of mem_address.

Behaviour:
- Reset: clear_n low asynchronously forces IDLE. All outputs go to 0, including instr, data_rdata and fault_addr. mem_write drops immediately, so a write in flight mid-cycle is aborted before the falling edge.
- Memory map (byte addresses):
  - Text window: 0x00400000–0x00400FFF.
  - Data window: 0x10010000–0x10010FFF.
  - Fetches are legal only in the text window.
  - Loads are legal in either window.
  - Stores are legal only in the data window.
  - Alignment follows the access size: word requires addr[1:0]=00; half requires addr[0]=0.
- Arbitration, evaluated in IDLE only: data_req beats ifetch_req. Requests arriving while busy wait.
- FSM states and transitions:
  - IDLE: latch the selected request. If illegal → FAULT. If full-word store → WRITE. Otherwise → READ with counter = WAIT_CYCLES and mem_address driven.
  - READ: mem_address held stable. When counter = 0, capture mem_read_data; a sub-word store goes → WRITE, anything else → RESP. Otherwise decrement the counter.
  - WRITE: mem_address, mem_write_data and mem_write=1 asserted for exactly one cycle, giving exactly one falling-edge commit → RESP.
  - RESP: pulse the owning ack for one cycle with err=0 → IDLE.
  - FAULT: pulse the owning ack with err=1, latch fault_addr, never assert mem_write → IDLE.
- Latency, counted from the accepting edge to the ack-high cycle:
  - Word load or fetch: 2+WAIT_CYCLES.
  - Word store: 2.
  - Sub-word store: 3+WAIT_CYCLES.
  - Fault: 1.
- Handshake: the requester must drop req on the edge after it sees ack. If req is still high in IDLE after RESP, it is treated as a new request.
- Request inputs are sampled only in IDLE. Changes during an access are ignored.
- mem_address holds its last value while in IDLE. mem_write is 0 in every state except WRITE.
- Load data is zero-extended from the addressed lane.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- Defined: data_size is honoured.
  - Half/byte loads select the lane by addr[1:0] and zero-extend.
  - Half/byte stores do read-modify-write: READ captures the word, merges the low bits of data_wdata into the addressed lane, then goes to WRITE.
- Undefined: data_size is ignored, every access is a word, and the merge logic is absent.

Decomposition:
- Shared package mem_map_pkg holds:
  - TEXT_BASE, TEXT_LIMIT, DATA_BASE, DATA_LIMIT.
  - Size encodings SZ_WORD/SZ_HALF/SZ_BYTE.
  - The FSM state encoding.
- One combinational sub-module, mem_access_check: inputs address, size, we, is_fetch; output legal. It is reused later by the exception logic.

Test Plan:
- After reset, ifetch_req at 0x00400000, WAIT_CYCLES=0 → ifetch_ack 2 cycles later, instr=0x00221820, err=0.
- data_req load at 0x10010004 with WAIT_CYCLES=3 → mem_address stable 4 cycles, data_ack at cycle 5, data_rdata=0x000000C8.
- Store 0x12345678 to 0x10010008, then load it → exactly one mem_write pulse; readback 0x12345678.
- Store to 0x00400000, then word load at 0x10010002 → each gives data_ack with err=1, fault_addr = the respective address, no mem_write.
- ifetch_req and data_req raised in the same cycle → data_ack first; ifetch_ack follows after re-arbitration. Also: clear_n low during WRITE → mem_write drops asynchronously and memory is unchanged.
- MEM_SUBWORD_EN: byte store 0xAB to 0x10010001 over a word holding 100 → word becomes 0x0000AB64; byte load at 0x10010001 → 0x000000AB.

Source files
------------

// File: rtl/mem_request_master_pkg.sv
// Memory map, access-size encodings and FSM states shared by the memory request master
// and the exception logic. Lane helpers are used only when MEM_SUBWORD_EN is defined.
package mem_map_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [ADDR_W-1:0] TEXT_LIMIT = 32'h0040_0FFF;
    localparam logic [ADDR_W-1:0] DATA_BASE  = 32'h1001_0000;
    localparam logic [ADDR_W-1:0] DATA_LIMIT = 32'h1001_0FFF;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP,
        ST_FAULT
    } state_e;

    // Zero-extended lane of a word selected by size and byte offset.
    function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        size,
                                                       input logic [1:0]        off);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {24'h0, sh[7:0]};
            SZ_HALF: res = {16'h0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of word with the low bits of wdata.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] word,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [1:0]        size,
                                                     input logic [1:0]        off);
        logic [DATA_W-1:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/mem_request_master_access_check.sv
// Combinational legality check of one access: address window by access kind plus
// natural alignment for the access size.
module mem_access_check
    import mem_map_pkg::*;
(
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        size,
    input  logic              we,
    input  logic              is_fetch,
    output logic              legal
);

    logic in_text;
    logic in_data;
    logic aligned;

    always_comb begin
        in_text = (address >= TEXT_BASE) && (address <= TEXT_LIMIT);
        in_data = (address >= DATA_BASE) && (address <= DATA_LIMIT);
        case (size)
            SZ_WORD: aligned = (address[1:0] == 2'b00);
            SZ_HALF: aligned = (address[0] == 1'b0);
            SZ_BYTE: aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
        if (is_fetch) begin
            legal = aligned && in_text;
        end else if (we) begin
            legal = aligned && in_data;
        end else begin
            legal = aligned && (in_text || in_data);
        end
    end

endmodule

// File: rtl/mem_request_master.sv
// Initiator for the shared instruction/data memory port: arbitration, legality check,
// wait-state timing and acknowledge. Define MEM_SUBWORD_EN for half/byte accesses.
module mem_request_master
    import mem_map_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_pc,
    output logic        ifetch_ack,
    output logic [31:0] instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        err,
    output logic [31:0] fault_addr,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_fetch_q, is_fetch_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ifetch_ack_q, ifetch_ack_d;
    logic               data_ack_q, data_ack_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
    logic [ADDR_W-1:0]  fault_addr_q, fault_addr_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic               mem_write_q, mem_write_d;
    logic [DATA_W-1:0]  mem_write_data_q, mem_write_data_d;
`ifdef MEM_SUBWORD_EN
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
`else
    logic               unused_size_c;
    assign unused_size_c = ^data_size;
`endif

    logic               sel_fetch_c;
    logic               sel_we_c;
    logic [1:0]         sel_size_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic               legal_c;

    // Data requests win arbitration over fetches.
    always_comb begin
        sel_fetch_c = !data_req;
        sel_we_c    = data_req && data_we;
        sel_addr_c  = data_req ? data_addr : ifetch_pc;
`ifdef MEM_SUBWORD_EN
        sel_size_c  = data_req ? data_size : SZ_WORD;
`else
        sel_size_c  = SZ_WORD;
`endif
    end

    mem_access_check u_check (
        .address  (sel_addr_c),
        .size     (sel_size_c),
        .we       (sel_we_c),
        .is_fetch (sel_fetch_c),
        .legal    (legal_c)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            is_fetch_q       <= 1'b0;
            addr_q           <= '0;
            ifetch_ack_q     <= 1'b0;
            data_ack_q       <= 1'b0;
            err_q            <= 1'b0;
            instr_q          <= '0;
            data_rdata_q     <= '0;
            fault_addr_q     <= '0;
            mem_address_q    <= '0;
            mem_write_q      <= 1'b0;
            mem_write_data_q <= '0;
`ifdef MEM_SUBWORD_EN
            we_q             <= 1'b0;
            size_q           <= SZ_WORD;
            wdata_q          <= '0;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            is_fetch_q       <= is_fetch_d;
            addr_q           <= addr_d;
            ifetch_ack_q     <= ifetch_ack_d;
            data_ack_q       <= data_ack_d;
            err_q            <= err_d;
            instr_q          <= instr_d;
            data_rdata_q     <= data_rdata_d;
            fault_addr_q     <= fault_addr_d;
            mem_address_q    <= mem_address_d;
            mem_write_q      <= mem_write_d;
            mem_write_data_q <= mem_write_data_d;
`ifdef MEM_SUBWORD_EN
            we_q             <= we_d;
            size_q           <= size_d;
            wdata_q          <= wdata_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_fetch_d       = is_fetch_q;
        addr_d           = addr_q;
        ifetch_ack_d     = 1'b0;
        data_ack_d       = 1'b0;
        err_d            = 1'b0;
        instr_d          = instr_q;
        data_rdata_d     = data_rdata_q;
        fault_addr_d     = fault_addr_q;
        mem_address_d    = mem_address_q;
        mem_write_d      = 1'b0;
        mem_write_data_d = mem_write_data_q;
`ifdef MEM_SUBWORD_EN
        we_d             = we_q;
        size_d           = size_q;
        wdata_d          = wdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (data_req || ifetch_req) begin
                    is_fetch_d = sel_fetch_c;
                    addr_d     = sel_addr_c;
`ifdef MEM_SUBWORD_EN
                    we_d       = sel_we_c;
                    size_d     = sel_size_c;
                    wdata_d    = data_wdata;
`endif
                    if (!legal_c) begin
                        state_d = ST_FAULT;
                    end else if (sel_we_c && (sel_size_c == SZ_WORD)) begin
                        state_d          = ST_WRITE;
                        mem_address_d    = sel_addr_c;
                        mem_write_d      = 1'b1;
                        mem_write_data_d = data_wdata;
                    end else begin
                        state_d       = ST_READ;
                        cnt_d         = CNT_W'(WAIT_CYCLES);
                        mem_address_d = sel_addr_c;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (is_fetch_q) begin
                        instr_d = mem_read_data;
`ifdef MEM_SUBWORD_EN
                    end else if (we_q) begin
                        // Read-modify-write: merged word goes out in the WRITE cycle.
                        state_d          = ST_WRITE;
                        mem_write_d      = 1'b1;
                        mem_write_data_d = lane_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
                    end else begin
                        data_rdata_d = lane_extract(mem_read_data, size_q, addr_q[1:0]);
                    end
`else
                    end else begin
                        data_rdata_d = mem_read_data;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                ifetch_ack_d = is_fetch_q;
                data_ack_d   = !is_fetch_q;
            end
            ST_FAULT: begin
                state_d      = ST_IDLE;
                ifetch_ack_d = is_fetch_q;
                data_ack_d   = !is_fetch_q;
                err_d        = 1'b1;
                fault_addr_d = addr_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ifetch_ack     = ifetch_ack_q;
    assign instr          = instr_q;
    assign data_ack       = data_ack_q;
    assign data_rdata     = data_rdata_q;
    assign err            = err_q;
    assign fault_addr     = fault_addr_q;
    assign mem_address    = mem_address_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench for mem_request_master: vector table of single accesses plus
// hand-written arbitration and reset-during-write sequences.
module tb_mem_request_master;
    import mem_map_pkg::*;

    localparam int unsigned W = 3;
    localparam int D = 2 + int'(W);

    logic        clock = 1'b0;
    logic        clear_n;
    logic        ifetch_req;
    logic [31:0] ifetch_pc;
    logic        ifetch_ack;
    logic [31:0] instr;
    logic        data_req;
    logic        data_we;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        err;
    logic [31:0] fault_addr;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] tmem [0:1023];
    logic [31:0] dmem [0:1023];
    int          wr_count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          writes;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    mem_request_master #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .ifetch_req     (ifetch_req),
        .ifetch_pc      (ifetch_pc),
        .ifetch_ack     (ifetch_ack),
        .instr          (instr),
        .data_req       (data_req),
        .data_we        (data_we),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_ack       (data_ack),
        .data_rdata     (data_rdata),
        .err            (err),
        .fault_addr     (fault_addr),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Memory model: combinational read, commit on falling edge.
    assign mem_read_data = (mem_address[31:12] == 20'h00400) ? tmem[mem_address[11:2]] :
                           (mem_address[31:12] == 20'h10010) ? dmem[mem_address[11:2]] : 32'h0;

    always @(negedge clock) begin
        if (mem_write) begin
            wr_count = wr_count + 1;
            if (mem_address[31:12] == 20'h10010) dmem[mem_address[11:2]] = mem_write_data;
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_data, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                                input logic e, input logic [31:0] rdata, input int writes);
        vec_t v;
        v.is_data = is_data; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = e; v.rdata = rdata; v.writes = writes;
        return v;
    endfunction

    task automatic run_access(input vec_t v, input int idx);
        int   n;
        int   w0;
        logic seen;
        logic wrong;
        w0 = wr_count; n = 0; seen = 1'b0; wrong = 1'b0;
        @(negedge clock);
        if (v.is_data) begin
            data_req = 1'b1; data_we = v.we; data_size = v.size;
            data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            ifetch_req = 1'b1; ifetch_pc = v.addr;
        end
        while (!seen && n < 60) begin
            @(posedge clock); #1;
            n = n + 1;
            if (v.is_data ? ifetch_ack : data_ack) wrong = 1'b1;
            if (v.is_data ? data_ack : ifetch_ack) seen = 1'b1;
        end
        ifetch_req = 1'b0; data_req = 1'b0;
        check("ack_seen", idx, 32'(seen), 32'd1);
        check("latency", idx, 32'(n - 1), 32'(v.lat));
        check("err", idx, 32'(err), 32'(v.err));
        if (v.err) check("fault_addr", idx, fault_addr, v.addr);
        else if (!v.we) check("rdata", idx, v.is_data ? data_rdata : instr, v.rdata);
        check("wrong_ack", idx, 32'(wrong), 32'd0);
        @(posedge clock); #1;
        check("ack_pulse", idx, 32'({ifetch_ack, data_ack}), 32'd0);
        check("writes", idx, 32'(wr_count - w0), 32'(v.writes));
    endtask

    initial begin
        int n, nd, nf, w0;
        n_tests = 0; n_fail = 0; wr_count = 0;
        for (int i = 0; i < 1024; i++) begin
            tmem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        tmem[0]    = 32'h0022_1820;
        tmem[1023] = 32'h0000_000C;
        dmem[0]    = 32'd100;
        dmem[1]    = 32'h0000_00C8;
        dmem[1023] = 32'h5A5A_5A5A;

        clear_n = 1'b0; ifetch_req = 1'b0; ifetch_pc = '0;
        data_req = 1'b0; data_we = 1'b0; data_size = SZ_WORD; data_addr = '0; data_wdata = '0;

        vecs.push_back(mk(0, 0, SZ_WORD, 32'h0040_0000, 0, D, 0, 32'h0022_1820, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_0004, 0, D, 0, 32'h0000_00C8, 0));
        vecs.push_back(mk(1, 1, SZ_WORD, 32'h1001_0008, 32'h1234_5678, 2, 0, 0, 1));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_0008, 0, D, 0, 32'h1234_5678, 0));
        vecs.push_back(mk(1, 1, SZ_WORD, 32'h0040_0000, 32'hFFFF_FFFF, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_0002, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, SZ_WORD, 32'h1001_0000, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h0040_0000, 0, D, 0, 32'h0022_1820, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_1000, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_0FFC, 0, D, 0, 32'h5A5A_5A5A, 0));
        vecs.push_back(mk(0, 0, SZ_WORD, 32'h0040_0FFC, 0, D, 0, 32'h0000_000C, 0));
        vecs.push_back(mk(0, 0, SZ_WORD, 32'h0040_0002, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h003F_FFFC, 0, 1, 1, 0, 0));
`ifdef MEM_SUBWORD_EN
        vecs.push_back(mk(1, 1, SZ_BYTE, 32'h1001_0001, 32'h0000_00AB, D + 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, SZ_BYTE, 32'h1001_0001, 0, D, 0, 32'h0000_00AB, 0));
        vecs.push_back(mk(1, 0, SZ_HALF, 32'h1001_0000, 0, D, 0, 32'h0000_AB64, 0));
        vecs.push_back(mk(1, 1, SZ_HALF, 32'h1001_0001, 32'h0000_1111, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, SZ_BYTE, 32'h1001_000B, 32'h0000_00CD, D + 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, SZ_WORD, 32'h1001_0008, 0, D, 0, 32'hCD34_5678, 0));
`else
        vecs.push_back(mk(1, 0, SZ_BYTE, 32'h1001_0001, 0, 1, 1, 0, 0));
`endif

        repeat (2) @(posedge clock);
        #1;
        check("rst_flags", 0, 32'({ifetch_ack, data_ack, err, mem_write}), 32'd0);
        check("rst_instr", 0, instr, 32'd0);
        check("rst_rdata", 0, data_rdata, 32'd0);
        check("rst_fault_addr", 0, fault_addr, 32'd0);
        check("rst_mem_address", 0, mem_address, 32'd0);
        @(negedge clock); clear_n = 1'b1;

        foreach (vecs[i]) run_access(vecs[i], i);

`ifdef MEM_SUBWORD_EN
        check("rmw_word", 0, dmem[0], 32'h0000_AB64);
`endif

        // Simultaneous requests: data first, fetch re-arbitrated after the data ack.
        @(negedge clock);
        data_req = 1'b1; data_we = 1'b0; data_size = SZ_WORD; data_addr = 32'h1001_0004;
        ifetch_req = 1'b1; ifetch_pc = 32'h0040_0000;
        n = 0; nd = 0; nf = 0;
        while (nf == 0 && n < 80) begin
            @(posedge clock); #1;
            n = n + 1;
            if (data_ack && nd == 0) begin nd = n; data_req = 1'b0; end
            if (ifetch_ack) begin nf = n; ifetch_req = 1'b0; end
        end
        data_req = 1'b0; ifetch_req = 1'b0;
        check("arb_data_first", 0, 32'(nd), 32'(D + 1));
        check("arb_fetch_after", 0, 32'(nf), 32'(2 * D + 2));
        check("arb_instr", 0, instr, 32'h0022_1820);
        check("arb_rdata", 0, data_rdata, 32'h0000_00C8);
        @(posedge clock); #1;

        // Reset asserted mid-WRITE: the strobe must drop before the falling edge.
        @(negedge clock);
        w0 = wr_count;
        data_req = 1'b1; data_we = 1'b1; data_size = SZ_WORD;
        data_addr = 32'h1001_000C; data_wdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        check("wr_asserted", 0, 32'(mem_write), 32'd1);
        data_req = 1'b0;
        #1 clear_n = 1'b0;
        #1 check("wr_abort", 0, 32'(mem_write), 32'd0);
        @(negedge clock); #1;
        check("mem_unchanged", 0, dmem[3], 32'd0);
        check("no_commit", 0, 32'(wr_count - w0), 32'd0);
        check("rst2_instr", 0, instr, 32'd0);
        check("rst2_mem_address", 0, mem_address, 32'd0);
        @(negedge clock); clear_n = 1'b1;

        run_access(mk(0, 0, SZ_WORD, 32'h0040_0000, 0, D, 0, 32'h0022_1820, 0), 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
